// File: rtl/ik_b2p_pkg.sv
// Shared framing constants and parser state for the HPS byte-to-packet path.
// Optional channel decoding is enabled with IK_B2P_CHANNEL_EN.
package ik_b2p_pkg;

    localparam logic [7:0] SOP_CHAR  = 8'h7A;
    localparam logic [7:0] EOP_CHAR  = 8'h7B;
    localparam logic [7:0] CHAN_CHAR = 8'h7C;
    localparam logic [7:0] ESC_CHAR  = 8'h7D;
    localparam logic [7:0] ESC_XOR   = 8'h20;

    typedef enum logic {
        IDLE = 1'b0,
        CHAN = 1'b1
    } b2p_state_e;

endpackage

// File: rtl/ik_swift_hps_master_0_b2p_out_stage.sv
// One-entry output register for the byte-to-packet converter.
// Holds the beat under backpressure and produces the upstream ready.
module ik_swift_hps_master_0_b2p_out_stage #(
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [7:0]               load_data,
    input  logic                     load_sop,
    input  logic                     load_eop,
    input  logic [CHANNEL_WIDTH-1:0] load_channel,
    output logic                     in_ready,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic [CHANNEL_WIDTH-1:0] out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket
);

    logic                     valid_q, valid_d;
    logic [7:0]               data_q, data_d;
    logic                     sop_q, sop_d;
    logic                     eop_q, eop_d;
    logic [CHANNEL_WIDTH-1:0] channel_q, channel_d;

    always_comb begin
        in_ready  = !reset && (!valid_q || out_ready);
        valid_d   = valid_q;
        data_d    = data_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        channel_d = channel_q;
        // Register is free (or being drained): reload or go empty.
        if (in_ready) begin
            valid_d = load;
            if (load) begin
                data_d    = load_data;
                sop_d     = load_sop;
                eop_d     = load_eop;
                channel_d = load_channel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            channel_q <= '0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            channel_q <= channel_d;
        end
    end

    assign out_valid         = valid_q;
    assign out_data          = data_q;
    assign out_channel       = channel_q;
    assign out_startofpacket = sop_q;
    assign out_endofpacket   = eop_q;

endmodule

// File: rtl/ik_swift_hps_master_0_b2p.sv
// Bytes-to-packets converter: strips in-band SOP/EOP/CHAN/ESC markers.
// Define IK_B2P_CHANNEL_EN to decode the channel; otherwise out_channel is 0.
module ik_swift_hps_master_0_b2p
    import ik_b2p_pkg::*;
#(
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic [CHANNEL_WIDTH-1:0] out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket
);

    b2p_state_e state_q, state_d;
    logic       sop_pend_q, sop_pend_d;
    logic       eop_pend_q, eop_pend_d;
    logic       esc_pend_q, esc_pend_d;

    logic       accept;
    logic       is_sop, is_eop, is_chan, is_esc, is_marker;
    logic [7:0] payload;
    logic       beat;
    logic [CHANNEL_WIDTH-1:0] beat_channel;

    assign accept    = in_valid && in_ready;
    assign is_sop    = !esc_pend_q && (in_data == SOP_CHAR);
    assign is_eop    = !esc_pend_q && (in_data == EOP_CHAR);
    assign is_chan   = !esc_pend_q && (in_data == CHAN_CHAR);
    assign is_esc    = !esc_pend_q && (in_data == ESC_CHAR);
    assign is_marker = is_sop || is_eop || is_chan || is_esc;
    assign payload   = esc_pend_q ? (in_data ^ ESC_XOR) : in_data;

    always_comb begin
        state_d    = state_q;
        sop_pend_d = sop_pend_q;
        eop_pend_d = eop_pend_q;
        esc_pend_d = esc_pend_q;
        beat       = 1'b0;
        if (accept) begin
            unique case (1'b1)
                is_sop: begin
                    sop_pend_d = 1'b1;
                    state_d    = IDLE;
                end
                is_eop: begin
                    eop_pend_d = 1'b1;
                    state_d    = IDLE;
                end
                is_chan: begin
                    state_d = CHAN;
                end
                is_esc: begin
                    esc_pend_d = 1'b1;
                end
                default: begin
                    esc_pend_d = 1'b0;
                    if (state_q == CHAN) begin
                        // Bit 7 set means more channel bytes follow.
                        if (!payload[7]) begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat       = 1'b1;
                        sop_pend_d = 1'b0;
                        eop_pend_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sop_pend_q <= 1'b0;
            eop_pend_q <= 1'b0;
            esc_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sop_pend_q <= sop_pend_d;
            eop_pend_q <= eop_pend_d;
            esc_pend_q <= esc_pend_d;
        end
    end

`ifdef IK_B2P_CHANNEL_EN
    localparam int SHW = CHANNEL_WIDTH + 7;

    logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;

    always_comb begin
        chan_d = chan_q;
        if (accept && is_chan) begin
            chan_d = '0;
        end else if (accept && !is_marker && (state_q == CHAN)) begin
            // 7 bits per byte, MSB group first; high bits fall off the top.
            chan_d = CHANNEL_WIDTH'({chan_q, 7'b0} | SHW'(payload[6:0]));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chan_q <= '0;
        end else begin
            chan_q <= chan_d;
        end
    end

    assign beat_channel = chan_q;
`else
    assign beat_channel = '0;
`endif

    ik_swift_hps_master_0_b2p_out_stage #(
        .CHANNEL_WIDTH(CHANNEL_WIDTH)
    ) u_out_stage (
        .clk               (clk),
        .reset             (reset),
        .load              (beat),
        .load_data         (payload),
        .load_sop          (sop_pend_q),
        .load_eop          (eop_pend_q),
        .load_channel      (beat_channel),
        .in_ready          (in_ready),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_channel       (out_channel),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket)
    );

endmodule

// File: tb/tb_ik_swift_hps_master_0_b2p.sv
// Directed bench for the HPS byte-to-packet converter.
// Channel expectations follow IK_B2P_CHANNEL_EN.
module tb_ik_swift_hps_master_0_b2p;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_ready;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [7:0] out_channel;
    logic       out_startofpacket;
    logic       out_endofpacket;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] got_q[$];

    always #5 clk = ~clk;

    ik_swift_hps_master_0_b2p #(
        .CHANNEL_WIDTH(8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_channel       (out_channel),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket)
    );

    // A beat transfers on the next posedge; inputs are stable from here.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            got_q.push_back({out_startofpacket, out_endofpacket,
                             out_channel, out_data});
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ech(input logic [7:0] v);
`ifdef IK_B2P_CHANNEL_EN
        return v;
`else
        return 8'h00;
`endif
    endfunction

    task automatic send(input logic [7:0] b);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_list(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send(bytes[i]);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input string tag, input int idx,
                               input logic [7:0] d, input logic s,
                               input logic e, input logic [7:0] c);
        logic [17:0] b;
        b = (idx < got_q.size()) ? got_q[idx] : 18'h3ffff;
        check({tag, "_data"}, {24'h0, b[7:0]}, {24'h0, d});
        check({tag, "_sop"}, {31'h0, b[17]}, {31'h0, s});
        check({tag, "_eop"}, {31'h0, b[16]}, {31'h0, e});
        check({tag, "_ch"}, {24'h0, b[15:8]}, {24'h0, c});
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'h0, out_valid}, 0);
        check("rst_ready", {31'h0, in_ready}, 0);
        check("rst_data", {24'h0, out_data}, 0);
        check("rst_ch", {24'h0, out_channel}, 0);
        check("rst_sop", {31'h0, out_startofpacket}, 0);
        check("rst_eop", {31'h0, out_endofpacket}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", {31'h0, in_ready}, 1);
        @(posedge clk);
        #1;

        // Basic packet with a single-byte channel
        got_q.delete();
        send_list('{8'h7A, 8'h7C, 8'h03, 8'h11, 8'h22, 8'h7B, 8'h33});
        check("t1_count", got_q.size(), 3);
        expect_beat("t1_b0", 0, 8'h11, 1'b1, 1'b0, ech(8'h03));
        expect_beat("t1_b1", 1, 8'h22, 1'b0, 1'b0, ech(8'h03));
        expect_beat("t1_b2", 2, 8'h33, 1'b0, 1'b1, ech(8'h03));

        // Escaped marker values as data; channel persists
        got_q.delete();
        send_list('{8'h7A, 8'h7D, 8'h5A, 8'h7D, 8'h5D, 8'h7B, 8'h7D, 8'h5B});
        check("t2_count", got_q.size(), 3);
        expect_beat("t2_b0", 0, 8'h7A, 1'b1, 1'b0, ech(8'h03));
        expect_beat("t2_b1", 1, 8'h7D, 1'b0, 1'b0, ech(8'h03));
        expect_beat("t2_b2", 2, 8'h7B, 1'b0, 1'b1, ech(8'h03));

        // Multi-byte channel, single-beat packet
        got_q.delete();
        send_list('{8'h7C, 8'h81, 8'h05, 8'h7A, 8'h7B, 8'h44});
        check("t3_count", got_q.size(), 1);
        expect_beat("t3_b0", 0, 8'h44, 1'b1, 1'b1, ech(8'h85));

        // Backpressure mid-packet
        got_q.delete();
        send(8'h7A);
        send(8'h01);
        out_ready = 1'b0;
        fork
            begin
                send(8'h02);
                send(8'h03);
                send(8'h7B);
                send(8'h04);
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("bp_valid", {31'h0, out_valid}, 1);
                    check("bp_data", {24'h0, out_data}, 8'h01);
                    check("bp_sop", {31'h0, out_startofpacket}, 1);
                    check("bp_ready", {31'h0, in_ready}, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("bp_count", got_q.size(), 4);
        expect_beat("bp_b0", 0, 8'h01, 1'b1, 1'b0, ech(8'h85));
        expect_beat("bp_b1", 1, 8'h02, 1'b0, 1'b0, ech(8'h85));
        expect_beat("bp_b2", 2, 8'h03, 1'b0, 1'b0, ech(8'h85));
        expect_beat("bp_b3", 3, 8'h04, 1'b0, 1'b1, ech(8'h85));

        // Reset in the middle of channel reception
        got_q.delete();
        send(8'h7A);
        send(8'h7C);
        send(8'h81);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_ready", {31'h0, in_ready}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_list('{8'h55});
        check("mrst_count", got_q.size(), 1);
        expect_beat("mrst_b0", 0, 8'h55, 1'b0, 1'b0, 8'h00);

        // Escaped channel byte, then repeated markers
        got_q.delete();
        send_list('{8'h7C, 8'h7D, 8'h5C, 8'h7A, 8'h66});
        check("t6_count", got_q.size(), 1);
        expect_beat("t6_b0", 0, 8'h66, 1'b1, 1'b0, ech(8'h7C));
        got_q.delete();
        send_list('{8'h7A, 8'h7A, 8'h7B, 8'h7B, 8'h77, 8'h78});
        check("t7_count", got_q.size(), 2);
        expect_beat("t7_b0", 0, 8'h77, 1'b1, 1'b1, ech(8'h7C));
        expect_beat("t7_b1", 1, 8'h78, 1'b0, 1'b0, ech(8'h7C));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ik_swift_hps_master_0_b2p.md
# ik_swift_hps_master_0_b2p

Bytes-to-packets converter for the HPS master byte channel. It consumes a raw Avalon-ST byte stream that carries in-band framing markers and escape sequences. It strips the markers and emits a packetised stream of data bytes with startofpacket, endofpacket and channel. It sits directly upstream of the b2p channel adapter and drives that adapter's `in_*` interface.

## Interface
- `CHANNEL_WIDTH`, 8: width of `out_channel`. Accumulated channel bits above this width are truncated.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `in_valid` in 1: raw byte valid.
- `in_data` in 8: raw byte.
- `out_ready` in 1: downstream ready.
- `out_valid` out 1: packet data beat valid.
- `out_data` out 8: unescaped data byte.
- `out_channel` out CHANNEL_WIDTH: channel in force for this beat.
- `out_startofpacket` out 1: first beat of packet.
- `out_endofpacket` out 1: last beat of packet.

## Operation
- Marker bytes, when received unescaped:
  - 0x7A (SOP): sets `sop_pend`.
  - 0x7B (EOP): sets `eop_pend`.
  - 0x7C (CHAN): clears the channel accumulator and enters CHAN state.
  - 0x7D (ESC): sets `esc_pend`.
- Any other byte is payload. If `esc_pend` is set, the byte is XORed with 0x20 and `esc_pend` clears.
- IDLE state: a payload byte becomes an output beat with `sop=sop_pend`, `eop=eop_pend` and the current channel. Both pend flags clear on that beat.
- CHAN state, payload byte b:
  - Update `chan <= (chan << 7) | b[6:0]`, truncated to CHANNEL_WIDTH.
  - If `b[7]=0`, return to IDLE. If `b[7]=1`, stay in CHAN.
  - No output beat is produced.
- Unescaped 0x7A, 0x7B or 0x7C received in CHAN state: channel reception ends with the value accumulated so far, then the marker is processed normally. For 0x7C this restarts the accumulation.
- 0x7D received in CHAN state escapes the next channel byte.
- ESC followed by any byte: the byte is always payload, never a marker. Example: 0x7D 0x5A produces data 0x7A.
- Repeated SOP or EOP markers before a data byte are idempotent.
- SOP and EOP both pending on the same data byte gives a single-beat packet with both flags set.
- The channel register persists across packets until the next CHAN marker.

## Timing
- Reset values:
  - Outputs: `out_valid`, `out_data`, `out_channel`, `out_startofpacket`, `out_endofpacket` all 0.
  - `in_ready` is 0 while `reset` is high.
  - Internal: state IDLE; `sop_pend`, `eop_pend`, `esc_pend` and the channel all cleared.
- `in_ready = !reset && (!out_valid || out_ready)`. This is combinational and there is no skid buffer.
- Latency: a payload byte accepted at cycle N appears on `out_*` at cycle N+1.
- Throughput: 1 byte per cycle. Marker, escape and channel bytes consume a cycle and produce no beat.
- Backpressure: while `out_valid && !out_ready`, all `out_*` signals hold stable and `in_ready` is 0.
- If a beat is taken and a new byte is accepted in the same cycle, the output register reloads or clears with no bubble.
- Reset asserted mid-packet discards all pending flags, the partial channel and the output beat on the next edge.

## Configuration
- `IK_B2P_CHANNEL_EN` defined:
  - Channel decoding is as above.
  - `out_channel` carries the decoded channel.
- `IK_B2P_CHANNEL_EN` undefined:
  - CHAN markers and channel bytes, including escaped ones, are still parsed and discarded so the stream stays framed.
  - `out_channel` is tied to 0.
  - The channel register is not built.

## Structure
- Package `ik_b2p_pkg` holds:
  - Constants SOP_CHAR=8'h7A, EOP_CHAR=8'h7B, CHAN_CHAR=8'h7C, ESC_CHAR=8'h7D, ESC_XOR=8'h20.
  - The parser state enum {IDLE, CHAN}.
- Sub-module `ik_swift_hps_master_0_b2p_out_stage` is the one-entry output register. It generates `in_ready` and holds data, sop, eop and channel under backpressure.
- The parser and pend flags live in the top module.

## Test plan
- Stream 7A 7C 03 11 22 7B 33 with `out_ready=1`: expect 3 beats.
  - Beat 1: 0x11, sop=1, ch=3.
  - Beat 2: 0x22, ch=3.
  - Beat 3: 0x33, eop=1, ch=3.
- Escape: 7A 7D 5A 7D 5D 7B 7D 5B: expect 3 beats.
  - Beat 1: 0x7A, sop=1.
  - Beat 2: 0x7D.
  - Beat 3: 0x7B, eop=1.
- Multi-byte channel with CHANNEL_WIDTH=8: 7C 81 05 7A 7B 44 gives ch=0x85, sop=1, eop=1, data 0x44.
- Backpressure: drive `out_ready=0` for 5 cycles mid-packet. `out_*` must hold, `in_ready` must be 0, and no byte may be lost or duplicated after release.
- Reset after 7A 7C 81: then send 55 and expect data 0x55, sop=0, ch=0.
- Build without `IK_B2P_CHANNEL_EN`: 7C 7D 5C 7A 66 gives 0x66, sop=1, ch=0, with no spurious beat from the escaped channel byte.
